oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/oam_dma_controller.sv | 147 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// OAM DMA controller: a CPU write to 16'h4014 halts the CPU and copies page {page,00..FF} to 16'h2004.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle when the transfer would start on a put cycle.
module oam_dma_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  input  logic [7:0]  bus_rdata,
  output logic        rdy,
  output logic        dma_active,
  output logic        dma_read,
  output logic        dma_write,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata
);

  localparam logic [15:0] TrigAddr    = 16'h4014;
  localparam logic [15:0] OamDataAddr = 16'h2004;

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StAlign = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StRead  = 3'd3,
    StWrite = 3'd4
  } state_e;
`endif

  state_e      state_q, state_d;
  logic        parity_q, parity_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;

  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        trigger;

  assign trigger = cpu_write && (cpu_addr == TrigAddr);

  always_comb begin
    state_d  = state_q;
    parity_d = parity_q;
    page_d   = page_q;
    index_d  = index_q;
    data_d   = data_q;
    if (cpu_en) begin
      parity_d = ~parity_q;
      case (state_q)
        StIdle: begin
          if (trigger) begin
            page_d  = cpu_wdata;
            index_d = 8'h00;
            state_d = StHalt;
          end
        end
        StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
          // The next cycle has parity ~parity_q; reads must land on get (parity 0) cycles.
          state_d = parity_q ? StRead : StAlign;
`else
          state_d = StRead;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        StAlign: state_d = StRead;
`endif
        StRead: begin
          data_d  = bus_rdata;
          state_d = StWrite;
        end
        StWrite: begin
          index_d = index_q + 8'd1;
          state_d = (index_q == 8'hFF) ? StIdle : StRead;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from next-state values so the registered copies track state_q exactly.
  always_comb begin
    rdy_d    = (state_d == StIdle);
    read_d   = (state_d == StRead);
    write_d  = (state_d == StWrite);
    active_d = read_d || write_d;
    addr_d   = 16'h0000;
    wdata_d  = 8'h00;
    if (read_d) begin
      addr_d = {page_d, index_d};
    end else if (write_d) begin
      addr_d  = OamDataAddr;
      wdata_d = data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      data_q   <= 8'h00;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      page_q   <= page_d;
      index_q  <= index_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rdy        = rdy_q;
  assign dma_active = active_q;
  assign dma_read   = read_q;
  assign dma_write  = write_q;
  assign dma_addr   = addr_q;
  assign dma_wdata  = wdata_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: table of idle-bus vectors plus scoreboarded full transfers.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  bus_rdata;
  logic        rdy;
  logic        dma_active;
  logic        dma_read;
  logic        dma_write;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  oam_dma_controller dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_write  (cpu_write),
    .bus_rdata  (bus_rdata),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_read   (dma_read),
    .dma_write  (dma_write),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bus_model(input logic [15:0] a);
    return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'hA5;
  endfunction

  assign bus_rdata = bus_model(dma_addr);

  int errors = 0;
  int checks = 0;
  logic        par_m = 1'b0;
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int halt_cnt, pre_cnt, rd_cnt, wr_cnt;

  typedef struct {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        exp_rdy;
    logic        exp_act;
    logic        exp_rdy2;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cpu_en    = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
  endtask

  // Consume the current CPU cycle against the scoreboard, then advance one clock.
  task automatic step();
    logic [15:0] ea;
    logic [7:0]  ed;
    if (cpu_en && !rst) begin
      if (!rdy) halt_cnt++;
      if (!rdy && !dma_active && rd_cnt == 0) pre_cnt++;
      if (dma_read) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", dma_addr, 16'hxxxx);
        end else begin
          ea = rd_q.pop_front();
          chk("rd_addr", dma_addr, ea);
          wr_q.push_back(bus_model(ea));
        end
        rd_cnt++;
      end
      if (dma_write) begin
        chk("wr_addr", dma_addr, 16'h2004);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {8'h00, dma_wdata}, 16'hxxxx);
        end else begin
          ed = wr_q.pop_front();
          chk("wr_data", {8'h00, dma_wdata}, {8'h00, ed});
        end
        wr_cnt++;
      end
    end
    if (dma_active === 1'b0) begin
      chk("idle_bus", {dma_read, dma_write, 6'd0, dma_wdata}, 16'h0000);
      chk("idle_addr", dma_addr, 16'h0000);
    end
    if (rst) par_m = 1'b0;
    else if (cpu_en) par_m = ~par_m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_transfer(input logic [7:0] page, input logic on_put, input int stall_at,
                             input int retrig_at, input int rst_at, input int exp_halt,
                             input int exp_pre);
    int budget;
    rd_q.delete();
    wr_q.delete();
    halt_cnt = 0;
    pre_cnt  = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
    idle_inputs();
    if (par_m != on_put) step();
    for (int i = 0; i < 256; i++) rd_q.push_back({page, i[7:0]});
    cpu_write = 1'b1;
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    step();
    idle_inputs();
    chk("trig_rdy", {15'd0, rdy}, 16'd0);
    budget = 0;
    while (!rdy && budget < 3000) begin
      if (dma_read && rd_cnt == stall_at) begin
        cpu_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
          step();
          chk("stall_read", {15'd0, dma_read}, 16'd1);
          chk("stall_addr", dma_addr, rd_q[0]);
        end
        cpu_en   = 1'b1;
        stall_at = -1;
      end else if (dma_read && rd_cnt == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rdy", {15'd0, rdy}, 16'd1);
        chk("rst_active", {15'd0, dma_active}, 16'd0);
        rd_q.delete();
        wr_q.delete();
        return;
      end else if (dma_read && rd_cnt == retrig_at) begin
        cpu_write = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'hEE;
        step();
        idle_inputs();
        retrig_at = -1;
      end else begin
        step();
      end
      budget++;
    end
    chk("xfer_done", {15'd0, rdy}, 16'd1);
    chk("halt_cycles", halt_cnt[15:0], exp_halt[15:0]);
    chk("pre_read_cycles", pre_cnt[15:0], exp_pre[15:0]);
    chk("read_count", rd_cnt[15:0], 16'd256);
    chk("write_count", wr_cnt[15:0], 16'd256);
    chk("rd_q_left", rd_q.size(), 16'd0);
    chk("wr_q_left", wr_q.size(), 16'd0);
  endtask

  initial begin
    vecs[0] = '{en: 1'b1, wr: 1'b1, addr: 16'h4015, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[1] = '{en: 1'b1, wr: 1'b1, addr: 16'h2014, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[2] = '{en: 1'b1, wr: 1'b0, addr: 16'h4014, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[3] = '{en: 1'b0, wr: 1'b1, addr: 16'h4014, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[4] = '{en: 1'b1, wr: 1'b1, addr: 16'h4013, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[5] = '{en: 1'b1, wr: 1'b1, addr: 16'hC014, wd: 8'h02, exp_rdy: 1'b1, exp_act: 1'b0, exp_rdy2: 1'b1};
    vecs[6] = '{en: 1'b1, wr: 1'b1, addr: 16'h4014, wd: 8'h02, exp_rdy: 1'b0, exp_act: 1'b0, exp_rdy2: 1'b0};
    halt_cnt = 0;
    pre_cnt  = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    chk("reset_rdy", {15'd0, rdy}, 16'd1);
    chk("reset_active", {15'd0, dma_active}, 16'd0);
    chk("reset_read", {15'd0, dma_read}, 16'd0);
    chk("reset_write", {15'd0, dma_write}, 16'd0);
    chk("reset_addr", dma_addr, 16'h0000);
    chk("reset_wdata", {8'h00, dma_wdata}, 16'h0000);

    for (int v = 0; v < 7; v++) begin
      cpu_en    = vecs[v].en;
      cpu_write = vecs[v].wr;
      cpu_addr  = vecs[v].addr;
      cpu_wdata = vecs[v].wd;
      step();
      chk("vec_rdy", {15'd0, rdy}, {15'd0, vecs[v].exp_rdy});
      chk("vec_active", {15'd0, dma_active}, {15'd0, vecs[v].exp_act});
      idle_inputs();
      step();
      chk("vec_rdy2", {15'd0, rdy}, {15'd0, vecs[v].exp_rdy2});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("table_rst_rdy", {15'd0, rdy}, 16'd1);

    do_transfer(8'h02, 1'b0, -1, -1, -1, 513, 1);
`ifdef OAM_DMA_ALIGN_EN
    do_transfer(8'h02, 1'b1, -1, -1, -1, 514, 2);
`else
    do_transfer(8'h02, 1'b1, -1, -1, -1, 513, 1);
`endif
    do_transfer(8'h35, 1'b0, 10, -1, -1, 513, 1);
    do_transfer(8'h5C, 1'b0, -1, 40, -1, 513, 1);
    do_transfer(8'h11, 1'b1, -1, -1, 128, 0, 0);
    do_transfer(8'h07, 1'b0, -1, -1, -1, 513, 1);

    idle_inputs();
    step();
    chk("final_rdy", {15'd0, rdy}, 16'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
